// File: rtl/pwm_ramp_ctrl.sv
// Sequencing controller in front of a PWM core: accepts period/duty/step/dwell configurations
// and ramps the core's duty cycle, changing core inputs only at PWM period boundaries.
module pwm_ramp_ctrl #(
   parameter int W  = 16,
   parameter int DW = 8
) (
   input  logic          clk_div,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [W-1:0]  cfg_period,
   input  logic [W-1:0]  cfg_duty,
   input  logic [W-1:0]  cfg_step,
   input  logic [DW-1:0] cfg_dwell,
   input  logic          stop,
   output logic [W-1:0]  period,
   output logic [W-1:0]  duty_cycle,
   output logic          enable,
   output logic          busy,
   output logic          done
);
   typedef enum logic [1:0] {IDLE, RAMP, HOLD, DRAIN} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  ph, ph_nx;
   logic [W-1:0]  tgt, tgt_nx;
   logic [W-1:0]  step, step_nx;
   logic [W-1:0]  shadow, shadow_nx;
   logic [W-1:0]  period_nx, duty_nx;
   logic [DW-1:0] dwell, dwell_nx;
   logic [DW-1:0] dc, dc_nx;
   logic          pend, pend_nx;
   logic          enable_nx, done_nx;

   logic [W-1:0]  pm1, goal, stepped, cfg_tgt;
   logic [W:0]    sum;
   logic [DW-1:0] cfg_dwell_eff;
   logic          bnd, accept, dwell_last;

   assign cfg_ready     = (state == IDLE) || (state == HOLD);
   assign busy          = (state != IDLE);
   assign accept        = cfg_valid && cfg_ready;
   assign pm1           = (period == '0) ? '0 : period - W'(1);
   assign bnd           = enable && (ph >= pm1);
   assign cfg_tgt       = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
   assign cfg_dwell_eff = (cfg_dwell == '0) ? DW'(1) : cfg_dwell;
   assign dwell_last    = (dc == dwell - DW'(1));

   // One step toward goal: the W+1-bit sum saturates upward, the difference test avoids a borrow downward.
   assign goal = (state == DRAIN) ? '0 : tgt;
   assign sum  = {1'b0, duty_cycle} + {1'b0, step};

   always_comb begin
      stepped = goal;
      if (step != '0) begin
         if (duty_cycle < goal)
            stepped = (sum > {1'b0, goal}) ? goal : sum[W-1:0];
         else if (duty_cycle - goal > step)
            stepped = duty_cycle - step;
      end
   end

   always_comb begin
      // NOTE: every next-value signal gets its hold value first, so no branch can infer a latch.
      state_nx   = state;
      ph_nx      = ph;
      tgt_nx     = tgt;
      step_nx    = step;
      dwell_nx   = dwell;
      dc_nx      = dc;
      shadow_nx  = shadow;
      pend_nx    = pend;
      period_nx  = period;
      duty_nx    = duty_cycle;
      enable_nx  = enable;
      done_nx    = 1'b0;

      if (enable) ph_nx = bnd ? '0 : ph + W'(1);
      if (bnd && pend) begin
         period_nx = shadow;
         pend_nx   = 1'b0;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               period_nx = cfg_period;
               enable_nx = 1'b1;
               duty_nx   = '0;
               dc_nx     = '0;
               tgt_nx    = cfg_tgt;
               step_nx   = cfg_step;
               dwell_nx  = cfg_dwell_eff;
               pend_nx   = 1'b0;
               state_nx  = RAMP;
            end
         end
         RAMP, HOLD: begin
            if (stop) begin
               state_nx = DRAIN;
               dc_nx    = '0;
            end else if (state == HOLD) begin
               if (accept) begin
                  tgt_nx    = cfg_tgt;
                  step_nx   = cfg_step;
                  dwell_nx  = cfg_dwell_eff;
                  shadow_nx = cfg_period;
                  pend_nx   = 1'b1;
                  dc_nx     = '0;
                  state_nx  = RAMP;
               end
            end else if (bnd) begin
               if (duty_cycle == tgt) begin
                  state_nx = HOLD;
                  dc_nx    = '0;
               end else if (dwell_last) begin
                  dc_nx   = '0;
                  duty_nx = stepped;
                  if (stepped == tgt) state_nx = HOLD;
               end else begin
                  dc_nx = dc + DW'(1);
               end
            end
         end
         DRAIN: begin
            if (bnd) begin
               if (duty_cycle == '0) begin
                  enable_nx = 1'b0;
                  done_nx   = 1'b1;
                  dc_nx     = '0;
                  state_nx  = IDLE;
               end else if (dwell_last) begin
                  dc_nx   = '0;
                  duty_nx = stepped;
               end else begin
                  dc_nx = dc + DW'(1);
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_div or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ph         <= '0;
         tgt        <= '0;
         step       <= '0;
         dwell      <= DW'(1);
         dc         <= '0;
         shadow     <= '0;
         pend       <= 1'b0;
         period     <= '0;
         duty_cycle <= '0;
         enable     <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nx;
         ph         <= ph_nx;
         tgt        <= tgt_nx;
         step       <= step_nx;
         dwell      <= dwell_nx;
         dc         <= dc_nx;
         shadow     <= shadow_nx;
         pend       <= pend_nx;
         period     <= period_nx;
         duty_cycle <= duty_nx;
         enable     <= enable_nx;
         done       <= done_nx;
      end
   end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus randomized traffic,
// all compared against an integer-arithmetic reference model of the ramp controller.
module tb_pwm_ramp_ctrl;
   localparam int W  = 16;
   localparam int DW = 8;
   localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_DRAIN = 3;
   localparam logic [2*W+3:0] RST_O = {16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0};

   logic          clk_div = 1'b0;
   logic          reset = 1'b1;
   logic          cfg_valid = 1'b0;
   logic          stop = 1'b0;
   logic [W-1:0]  cfg_period = '0, cfg_duty = '0, cfg_step = '0;
   logic [DW-1:0] cfg_dwell = '0;
   logic          cfg_ready, enable, busy, done;
   logic [W-1:0]  period, duty_cycle;

   int n_tests = 0;
   int n_fail  = 0;

   int m_state, m_ph, m_dc, m_tgt, m_step, m_dwell, m_period, m_duty, m_shadow;
   bit m_en, m_done, m_pend;

   wire [2*W+3:0] dut_o = {period, duty_cycle, enable, cfg_ready, busy, done};

   pwm_ramp_ctrl #(.W(W), .DW(DW)) dut (
      .clk_div    (clk_div),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_duty   (cfg_duty),
      .cfg_step   (cfg_step),
      .cfg_dwell  (cfg_dwell),
      .stop       (stop),
      .period     (period),
      .duty_cycle (duty_cycle),
      .enable     (enable),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk_div = ~clk_div;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int toward(int d, int t, int s);
      if (s == 0) return t;
      if (d < t) return (d + s > t) ? t : d + s;
      return (d - s < t) ? t : d - s;
   endfunction

   function automatic logic [2*W+3:0] m_outs();
      logic rdy;
      rdy = (m_state == S_IDLE) || (m_state == S_HOLD);
      return {W'(m_period), W'(m_duty), m_en, rdy, (m_state != S_IDLE), m_done};
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_ph = 0; m_dc = 0; m_tgt = 0; m_step = 0; m_dwell = 1;
      m_period = 0; m_duty = 0; m_shadow = 0; m_en = 0; m_done = 0; m_pend = 0;
   endtask

   task automatic latch_cfg();
      m_tgt   = (cfg_duty > cfg_period) ? int'(cfg_period) : int'(cfg_duty);
      m_step  = int'(cfg_step);
      m_dwell = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
   endtask

   // Advances one clock edge and the model with it; outputs are sampled 1 time unit later.
   task automatic tick();
      int pm1;
      bit bnd, acc;
      pm1 = (m_period == 0) ? 0 : m_period - 1;
      bnd = m_en && (m_ph >= pm1);
      acc = cfg_valid && ((m_state == S_IDLE) || (m_state == S_HOLD));
      @(posedge clk_div);
      m_done = 0;
      if (m_en) m_ph = bnd ? 0 : m_ph + 1;
      if (bnd && m_pend) begin m_period = m_shadow; m_pend = 0; end
      case (m_state)
         S_IDLE: if (acc) begin
            m_period = int'(cfg_period); m_en = 1; m_duty = 0; m_dc = 0; m_pend = 0;
            latch_cfg(); m_state = S_RAMP;
         end
         S_RAMP, S_HOLD: begin
            if (stop) begin
               m_state = S_DRAIN; m_dc = 0;
            end else if (m_state == S_HOLD) begin
               if (acc) begin
                  latch_cfg(); m_shadow = int'(cfg_period); m_pend = 1; m_dc = 0; m_state = S_RAMP;
               end
            end else if (bnd) begin
               if (m_duty == m_tgt) begin
                  m_state = S_HOLD; m_dc = 0;
               end else if (m_dc == m_dwell - 1) begin
                  m_dc = 0; m_duty = toward(m_duty, m_tgt, m_step);
                  if (m_duty == m_tgt) m_state = S_HOLD;
               end else m_dc++;
            end
         end
         default: if (bnd) begin
            if (m_duty == 0) begin
               m_en = 0; m_done = 1; m_dc = 0; m_state = S_IDLE;
            end else if (m_dc == m_dwell - 1) begin
               m_dc = 0; m_duty = toward(m_duty, 0, m_step);
            end else m_dc++;
         end
      endcase
      #1;
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      cfg_valid = 0; stop = 0; reset = 1; model_reset();
      @(posedge clk_div); #1;
      reset = 0;
   endtask

   task automatic offer(input int p, input int d, input int s, input int dw);
      cfg_period = W'(p); cfg_duty = W'(d); cfg_step = W'(s); cfg_dwell = DW'(dw);
      cfg_valid = 1;
      tick();
      cfg_valid = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1; model_reset(); #3;
      n_tests++;
      if (dut_o !== RST_O) begin n_fail++; $display("FAIL reset_outputs: got %h need %h", dut_o, RST_O); end
      n_tests++;
      if (dut.ph !== '0) begin n_fail++; $display("FAIL reset_ph: got %0d need 0", dut.ph); end
      @(posedge clk_div); #1;
      reset = 0;
      tick();
      n_tests++;
      if (dut_o !== RST_O) begin n_fail++; $display("FAIL reset_idle: got %h need %h", dut_o, RST_O); end
   endtask

   task automatic test_basic_ramp();
      int cyc, pre_ph;
      longint hist;
      logic [W-1:0] prev;
      do_reset();
      offer(10, 6, 2, 1);
      n_tests++;
      if (dut_o !== m_outs()) begin n_fail++; $display("FAIL basic_accept: got %h need %h", dut_o, m_outs()); end
      hist = 0; cyc = 0;
      while (m_state != S_HOLD && cyc < 60) begin
         pre_ph = m_ph; prev = duty_cycle;
         tick(); cyc++;
         n_tests++;
         if (dut_o !== m_outs()) begin n_fail++; $display("FAIL basic_cycle %0d: got %h need %h", cyc, dut_o, m_outs()); end
         if (duty_cycle !== prev) begin
            hist = (hist << 8) | longint'(duty_cycle[7:0]);
            n_tests++;
            if (pre_ph != 9) begin n_fail++; $display("FAIL basic_edge: duty changed at ph %0d need 9", pre_ph); end
         end
      end
      n_tests++;
      if (hist != 64'h020406 || cyc != 30) begin
         n_fail++; $display("FAIL basic_seq: steps %h after %0d cycles, need 020406 after 30", hist, cyc);
      end
      n_tests++;
      if (cfg_ready !== 1'b1 || duty_cycle !== 16'd6) begin
         n_fail++; $display("FAIL basic_hold: ready %b duty %0d, need 1 and 6", cfg_ready, duty_cycle);
      end
   endtask

   task automatic test_clamp();
      int cyc;
      longint hist;
      logic [W-1:0] prev;
      do_reset();
      offer(8, 20, 5, 2);
      n_tests++;
      if (dut.tgt !== 16'd8) begin n_fail++; $display("FAIL clamp_tgt: got %0d need 8", dut.tgt); end
      hist = 0; cyc = 0;
      while (m_state != S_HOLD && cyc < 100) begin
         prev = duty_cycle;
         tick(); cyc++;
         n_tests++;
         if (dut_o !== m_outs() || duty_cycle > 16'd8) begin
            n_fail++; $display("FAIL clamp_cycle %0d: got %h need %h", cyc, dut_o, m_outs());
         end
         if (duty_cycle !== prev) hist = (hist << 8) | longint'(duty_cycle[7:0]);
      end
      n_tests++;
      if (hist != 64'h0508 || cyc != 32) begin
         n_fail++; $display("FAIL clamp_seq: steps %h after %0d cycles, need 0508 after 32", hist, cyc);
      end
   endtask

   task automatic test_step_zero();
      do_reset();
      offer(8, 20, 0, 1);
      repeat (7) begin
         tick();
         n_tests++;
         if (dut_o !== m_outs()) begin n_fail++; $display("FAIL step0_cycle: got %h need %h", dut_o, m_outs()); end
      end
      n_tests++;
      if (duty_cycle !== '0) begin n_fail++; $display("FAIL step0_early: duty %0d need 0", duty_cycle); end
      tick();
      n_tests++;
      if (duty_cycle !== 16'd8 || cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL step0_jump: duty %0d ready %b, need 8 and 1", duty_cycle, cfg_ready);
      end
   endtask

   task automatic test_retarget();
      int cyc, pre_ph;
      longint hist;
      logic [W-1:0] prev_d, prev_p;
      do_reset();
      offer(10, 8, 8, 1);
      repeat (10) tick();
      n_tests++;
      if (duty_cycle !== 16'd8 || cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL retarget_hold: duty %0d ready %b, need 8 and 1", duty_cycle, cfg_ready);
      end
      repeat (3) tick();
      offer(12, 3, 2, 1);
      n_tests++;
      if (period !== 16'd10 || cfg_ready !== 1'b0) begin
         n_fail++; $display("FAIL retarget_accept: period %0d ready %b, need 10 and 0", period, cfg_ready);
      end
      hist = 0; cyc = 0;
      while (m_state != S_HOLD && cyc < 100) begin
         pre_ph = m_ph; prev_d = duty_cycle; prev_p = period;
         tick(); cyc++;
         n_tests++;
         if (dut_o !== m_outs()) begin n_fail++; $display("FAIL retarget_cycle %0d: got %h need %h", cyc, dut_o, m_outs()); end
         if (duty_cycle !== prev_d) hist = (hist << 8) | longint'(duty_cycle[7:0]);
         if (period !== prev_p) begin
            n_tests++;
            if (pre_ph != 9 || duty_cycle === prev_d) begin
               n_fail++; $display("FAIL retarget_period_edge: period moved at ph %0d, need 9 with a duty step", pre_ph);
            end
         end
      end
      n_tests++;
      if (hist != 64'h060403 || period !== 16'd12 || cfg_ready !== 1'b1) begin
         n_fail++; $display("FAIL retarget_seq: steps %h period %0d ready %b, need 060403 12 1", hist, period, cfg_ready);
      end
   endtask

   task automatic test_stop();
      int cyc, dones;
      longint hist;
      logic [W-1:0] prev;
      logic prev_en;
      do_reset();
      offer(10, 8, 2, 1);
      repeat (20) tick();
      n_tests++;
      if (duty_cycle !== 16'd4 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL stop_pre: duty %0d ready %b busy %b, need 4 0 1", duty_cycle, cfg_ready, busy);
      end
      cfg_period = 16'd10; cfg_duty = 16'd9; cfg_step = 16'd1; cfg_dwell = 8'd1;
      cfg_valid = 1; stop = 1;
      tick();
      cfg_valid = 0; stop = 0;
      n_tests++;
      if (cfg_ready !== 1'b0 || busy !== 1'b1 || dut.tgt !== 16'd8 || dut.step !== 16'd2) begin
         n_fail++; $display("FAIL stop_precedence: ready %b busy %b tgt %0d step %0d, need 0 1 8 2",
                            cfg_ready, busy, dut.tgt, dut.step);
      end
      hist = 0; cyc = 0; dones = 0;
      while (m_en && cyc < 100) begin
         prev = duty_cycle; prev_en = enable;
         tick(); cyc++;
         n_tests++;
         if (dut_o !== m_outs()) begin n_fail++; $display("FAIL stop_cycle %0d: got %h need %h", cyc, dut_o, m_outs()); end
         if (duty_cycle !== prev) hist = (hist << 8) | longint'(duty_cycle[7:0]);
         if (done === 1'b1) begin
            dones++;
            n_tests++;
            if (prev_en !== 1'b1 || enable !== 1'b0) begin
               n_fail++; $display("FAIL stop_done_align: done with enable %b->%b, need 1->0", prev_en, enable);
            end
         end
      end
      tick();
      n_tests++;
      if (hist != 64'h0200 || dones != 1 || done !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL stop_end: steps %h dones %0d done %b ready %b busy %b, need 0200 1 0 1 0",
                            hist, dones, done, cfg_ready, busy);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      offer(10, 8, 2, 1);
      repeat (25) tick();
      stop = 1;
      tick();
      stop = 0;
      repeat (5) tick();
      n_tests++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0 || enable !== 1'b1) begin
         n_fail++; $display("FAIL drain_state: busy %b ready %b enable %b, need 1 0 1", busy, cfg_ready, enable);
      end
      #3 reset = 1;
      #1;
      n_tests++;
      if (dut_o !== RST_O || dut.ph !== '0) begin
         n_fail++; $display("FAIL async_reset: got %h ph %0d, need %h ph 0", dut_o, dut.ph, RST_O);
      end
      model_reset();
      @(posedge clk_div); #1;
      reset = 0;
      offer(10, 4, 1, 1);
      repeat (60) begin
         tick();
         n_tests++;
         if (dut_o !== m_outs() || dut.ph !== W'(m_ph)) begin
            n_fail++; $display("FAIL restart_cycle: got %h ph %0d, need %h ph %0d", dut_o, dut.ph, m_outs(), m_ph);
         end
      end
   endtask

   task automatic test_degenerate();
      do_reset();
      offer(0, 5, 3, 1);
      n_tests++;
      if (enable !== 1'b1 || period !== '0 || dut.tgt !== '0) begin
         n_fail++; $display("FAIL degen_accept: enable %b period %0d tgt %0d, need 1 0 0", enable, period, dut.tgt);
      end
      tick();
      n_tests++;
      if (cfg_ready !== 1'b1 || duty_cycle !== '0 || dut_o !== m_outs()) begin
         n_fail++; $display("FAIL degen_hold: got %h need %h", dut_o, m_outs());
      end
      repeat (5) begin
         n_tests++;
         if (dut.bnd !== 1'b1) begin n_fail++; $display("FAIL degen_bnd: got %b need 1", dut.bnd); end
         tick();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         cfg_period = W'($urandom_range(0, 12));
         cfg_duty   = W'($urandom_range(0, 15));
         cfg_step   = W'($urandom_range(0, 4));
         cfg_dwell  = DW'($urandom_range(0, 3));
         cfg_valid  = ($urandom_range(0, 9) == 0);
         stop       = ($urandom_range(0, 49) == 0);
         tick();
         n_tests++;
         if (dut_o !== m_outs() || dut.ph !== W'(m_ph)) begin
            n_fail++; $display("FAIL random_cycle %0d: got %h ph %0d, need %h ph %0d", i, dut_o, dut.ph, m_outs(), m_ph);
         end
      end
      cfg_valid = 0; stop = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_ramp();
      test_clamp();
      test_step_zero();
      test_retarget();
      test_stop();
      test_reset_mid_drain();
      test_degenerate();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
